// File: rtl/key_pattern_loader.sv
// key_pattern_loader: Avalon-MM master that disables the matcher, writes the pattern words,
// writes the enable word, then reads every pattern word back and checks it.
module key_pattern_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_DEPTH  = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic                                 start_i,
    input  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] pattern_i,
    input  logic                                 enable_i,
    output logic [ADDR_WIDTH-1:0]                amm_address_o,
    output logic                                 amm_write_o,
    output logic [DATA_WIDTH-1:0]                amm_writedata_o,
    output logic                                 amm_read_o,
    input  logic                                 amm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]                amm_readdata_i,
    input  logic                                 amm_readdatavalid_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [ADDR_WIDTH-1:0]                err_addr_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_DIS  = 3'd1;
    localparam logic [2:0] WR_PAT  = 3'd2;
    localparam logic [2:0] WR_EN   = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
    localparam logic [2:0] RD_WAIT = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;
    localparam int KW = REG_DEPTH > 1 ? $clog2(REG_DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]                           state;
    logic [KW-1:0]                        k;
    logic [CW-1:0]                        cnt;
    logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] pat;
    logic                                 en;
    logic [ADDR_WIDTH-1:0]                k_addr;
    logic                                 last;

    assign k_addr = ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
    assign last   = k == KW'(REG_DEPTH - 1);

    // Bus outputs depend only on state, so they stay stable across waitrequest stalls
    assign amm_write_o     = state == WR_DIS || state == WR_PAT || state == WR_EN;
    assign amm_read_o      = state == RD_REQ;
    assign amm_address_o   = (state == WR_PAT || state == RD_REQ) ? k_addr : '0;
    assign amm_writedata_o = state == WR_PAT ? pat[k] : state == WR_EN ? DATA_WIDTH'(en) : '0;
    assign busy_o          = state != IDLE && state != FIN;
    assign done_o          = state == FIN;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state      <= IDLE;
            k          <= '0;
            cnt        <= '0;
            pat        <= '0;
            en         <= 1'b0;
            error_o    <= 1'b0;
            err_addr_o <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    pat        <= pattern_i;
                    en         <= enable_i;
                    error_o    <= 1'b0;
                    err_addr_o <= '0;
                    state      <= WR_DIS;
                end
                WR_DIS: if (!amm_waitrequest_i) begin
                    k     <= '0;
                    state <= WR_PAT;
                end
                WR_PAT: if (!amm_waitrequest_i) begin
                    k     <= last ? '0 : k + 1'b1;
                    state <= last ? WR_EN : WR_PAT;
                end
                WR_EN: if (!amm_waitrequest_i) begin
                    k     <= '0;
                    state <= RD_REQ;
                end
                RD_REQ: if (!amm_waitrequest_i) begin
                    cnt   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Valid data wins over a timeout landing in the same cycle
                    if (amm_readdatavalid_i) begin
                        if (amm_readdata_i != pat[k]) begin
                            error_o    <= 1'b1;
                            err_addr_o <= k_addr;
                            state      <= FIN;
                        end else if (last) begin
                            state <= FIN;
                        end else begin
                            k     <= k + 1'b1;
                            state <= RD_REQ;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        error_o    <= 1'b1;
                        err_addr_o <= k_addr;
                        state      <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_pattern_loader.sv
// tb_key_pattern_loader: directed bench with a small Avalon slave memory and
// hand-computed sequence latencies and bus transactions.
module tb_key_pattern_loader;
    logic             clk = 1'b0;
    logic             srst = 1'b0;
    logic             start = 1'b0;
    logic [2:0][31:0] pattern = '0;
    logic             enable = 1'b0;
    logic [3:0]       address;
    logic             write;
    logic [31:0]      wdata;
    logic             read;
    logic             waitreq;
    logic [31:0]      rdata;
    logic             rdv;
    logic             busy;
    logic             done;
    logic             error;
    logic [3:0]       err_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    logic [35:0] wlog [$];
    int          rlog [$];
    logic        stall_en = 1'b0;
    int          stall_done = 0;
    int          corrupt_addr = 0;
    int          hold_addr = 0;
    int          a2_cycles = 0;
    int          rw_both = 0;
    int          done_cnt = 0;

    key_pattern_loader dut (
        .clk_i              (clk),
        .srst_i             (srst),
        .start_i            (start),
        .pattern_i          (pattern),
        .enable_i           (enable),
        .amm_address_o      (address),
        .amm_write_o        (write),
        .amm_writedata_o    (wdata),
        .amm_read_o         (read),
        .amm_waitrequest_i  (waitreq),
        .amm_readdata_i     (rdata),
        .amm_readdatavalid_i(rdv),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error),
        .err_addr_o         (err_addr)
    );

    always #5 clk = ~clk;

    // Stall the address-2 write for exactly three cycles when enabled
    assign waitreq = stall_en && write && address == 4'd2 && stall_done < 3;

    always @(posedge clk) begin
        if (write && read) rw_both++;
        if (write && address == 4'd2 && wdata == 32'hB1B2B3B4) a2_cycles++;
        if (waitreq) stall_done++;
        if (done) done_cnt++;
        if (write && !waitreq) begin
            wlog.push_back({address, wdata});
            mem[address] = wdata;
        end
        rdv <= 1'b0;
        if (read && !waitreq) begin
            rlog.push_back(int'(address));
            rdv   <= int'(address) != hold_addr;
            rdata <= int'(address) == corrupt_addr ? 32'hDEADBEEF : mem[address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] p0, p1, p2, input logic en, input int extra_at, output int lat);
        @(negedge clk);
        pattern = {p2, p1, p0};
        enable  = en;
        start   = 1'b1;
        lat     = -1;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            start = c == extra_at;
            if (c == 1) begin
                pattern = ~pattern;
                enable  = ~enable;
                chk("err_clr", error, 0);
            end
            if (done) lat = c;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_1cyc", {busy, done}, 0);
    endtask

    task automatic check_writes(input int wb, input logic [31:0] p0, p1, p2, input logic en);
        logic [35:0] exp [5];
        exp = '{{4'd0, 32'd0}, {4'd1, p0}, {4'd2, p1}, {4'd3, p2}, {4'd0, 31'd0, en}};
        chk("wr_n", wlog.size() - wb, 5);
        for (int i = 0; i < 5; i++)
            if (wb + i < wlog.size()) chk("wr", wlog[wb + i], exp[i]);
    endtask

    task automatic check_reads(input int rb, input int n);
        chk("rd_n", rlog.size() - rb, n);
        for (int i = 0; i < n; i++)
            if (rb + i < rlog.size()) chk("rd", rlog[rb + i], i + 1);
    endtask

    initial begin
        int lat, wb, rb, a0, d0;
        #1 srst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_status", {busy, done, error, err_addr}, 0);
        chk("rst_bus", {write, read, address, wdata}, 0);
        srst = 1'b0;
        repeat (2) @(negedge clk);

        wb = wlog.size(); rb = rlog.size();
        run(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1'b1, 0, lat);
        chk("lat_nostall", lat, 12);
        chk("err_nostall", {error, err_addr}, 0);
        check_writes(wb, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1'b1);
        check_reads(rb, 3);

        wb = wlog.size(); rb = rlog.size(); a0 = a2_cycles;
        stall_en = 1'b1;
        run(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1'b1, 0, lat);
        stall_en = 1'b0;
        chk("lat_stall", lat, 15);
        chk("stall_hold", a2_cycles - a0, 4);
        chk("err_stall", error, 0);
        check_writes(wb, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1'b1);
        check_reads(rb, 3);

        wb = wlog.size(); rb = rlog.size();
        corrupt_addr = 2;
        run(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 1'b1, 0, lat);
        corrupt_addr = 0;
        chk("lat_mismatch", lat, 10);
        chk("err_mismatch", {error, err_addr}, {1'b1, 4'd2});
        check_reads(rb, 2);

        wb = wlog.size(); rb = rlog.size();
        hold_addr = 1;
        run(32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 0, lat);
        hold_addr = 0;
        chk("lat_timeout", lat, 23);
        chk("err_timeout", {error, err_addr}, {1'b1, 4'd1});
        check_writes(wb, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1);
        check_reads(rb, 1);

        wb = wlog.size(); rb = rlog.size(); d0 = done_cnt;
        run(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0, 3, lat);
        repeat (20) @(negedge clk);
        chk("lat_extra", lat, 12);
        chk("done_once", done_cnt - d0, 1);
        chk("err_extra", {error, err_addr}, 0);
        check_writes(wb, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0);
        check_reads(rb, 3);

        @(negedge clk);
        pattern = {32'h3, 32'h2, 32'h1};
        enable  = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_pre_rst", {busy, write}, 2'b11);
        srst = 1'b1;
        #1;
        chk("rst_async", {busy, write, read, done}, 0);
        @(negedge clk);
        srst = 1'b0;
        wb = wlog.size(); rb = rlog.size();
        repeat (10) @(negedge clk);
        chk("rst_quiet_wr", wlog.size() - wb, 0);
        chk("rst_quiet_rd", rlog.size() - rb, 0);
        chk("rst_idle", {busy, error}, 0);

        chk("rw_excl", rw_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
